// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: AES-128 decryption round-key generator, presents round keys 10 down to 0
// Ports: clk clock; rst async active-high reset; ld start strobe (accepted only when idle);
//        key 128-bit cipher key (byte 0 in [127:120]); rk current round key; rnd its round index;
//        rk_vld rk/rnd valid; busy run in progress; done one-cycle pulse after round key 0.
// Macro AES_INV_KS_ZEROIZE_EN: when defined, working words and rk clear at the end of each run.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, s;
    p = '0;
    s = x;
    for (int i = 0; i < 8; i++) begin
      p = z[i] ? p ^ s : p;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] sq, inv;
  // multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128, then the affine transform
  always_comb begin
    sq = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  output logic [127:0] rk,
  output logic [3:0]   rnd,
  output logic         rk_vld,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT, FIN} state_t;
  state_t st, nxt;
  logic [31:0] w0, w1, w2, w3, iw3, sw_in, rot, sw, t, f0, f1, f2, f3;
  logic [3:0] cnt, ri;
  logic [7:0] rc;
  logic [127:0] fwd, inv;
  // the S-boxes serve the forward step on w3 and the inverse step on the recovered w3
  assign iw3 = w3 ^ w2;
  assign sw_in = (st == EMIT) ? iw3 : w3;
  assign rot = {sw_in[23:0], sw_in[31:24]};
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_sb
      aes_sbox u_sb (.a(rot[8*i +: 8]), .y(sw[8*i +: 8]));
    end
  endgenerate
  assign ri = (st == EMIT) ? rnd - 4'd1 : cnt;
  assign rc = (ri < 4'd8) ? 8'h01 << ri : (ri == 4'd8) ? 8'h1b : 8'h36;
  assign t = sw ^ {rc, 24'h0};
  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign fwd = {f0, f1, f2, f3};
  assign inv = {w0 ^ t, w1 ^ w0, w2 ^ w1, iw3};
  always_comb begin
    nxt = st == IDLE   ? (ld ? EXPAND : IDLE) :
          st == EXPAND ? (cnt == 4'd9 ? EMIT : EXPAND) :
          st == EMIT   ? (rnd == 4'd1 ? FIN : EMIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {w0, w1, w2, w3} <= '0;
      rk <= '0;
      rnd <= '0;
      cnt <= '0;
      rk_vld <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (ld) begin
          {w0, w1, w2, w3} <= key;
          cnt <= '0;
          busy <= 1'b1;
        end
        EXPAND: begin
          {w0, w1, w2, w3} <= fwd;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            rk <= fwd;
            rnd <= 4'd10;
            rk_vld <= 1'b1;
          end
        end
        EMIT: begin
          {w0, w1, w2, w3} <= inv;
          rk <= inv;
          rnd <= rnd - 4'd1;
        end
        default: begin
          rk_vld <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
`ifdef AES_INV_KS_ZEROIZE_EN
          {w0, w1, w2, w3} <= '0;
          rk <= '0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: scoreboard bench for aes_inv_key_sched against a key-expansion model
module tb_aes_inv_key_sched;
  logic clk, rst, ld, rk_vld, busy, done;
  logic [127:0] key, rk;
  logic [3:0] rnd;
`ifdef AES_INV_KS_ZEROIZE_EN
  localparam bit ZER = 1'b1;
`else
  localparam bit ZER = 1'b0;
`endif
  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KC = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  typedef struct {logic [127:0] rk; logic [3:0] rnd; int cyc;} ent_t;
  typedef struct {int cyc; logic [127:0] hold;} dn_t;
  ent_t sq[$];
  dn_t dq[$];
  ent_t e;
  dn_t d;
  logic [7:0] sb[256];
  logic [127:0] rkm[11];
  logic [127:0] lastk;
  int cyc = 0, checks = 0, errors = 0, last_e0 = 0, base;
  bit active = 0;

  aes_inv_key_sched dut (.clk(clk), .rst(rst), .ld(ld), .key(key), .rk(rk), .rnd(rnd),
                         .rk_vld(rk_vld), .busy(busy), .done(done));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkm[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // drive ld for one cycle from a negedge; queue expectations only if the block should accept it
  task automatic issue_ld(input logic [127:0] k);
    int ed;
    ld = 1'b1;
    key = k;
    ed = cyc + 1;
    if (!active || ed >= last_e0 + 22) begin
      expand(k);
      for (int i = 0; i <= 10; i++) sq.push_back('{rkm[10-i], 4'(10-i), ed + 10 + i});
      dq.push_back('{ed + 21, ZER ? 128'h0 : rkm[0]});
      active = 1;
      last_e0 = ed;
      lastk = k;
    end
    @(negedge clk);
    ld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, active && cyc >= last_e0 && cyc <= last_e0 + 20);
      if (rk_vld) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rk_spurious got rnd=%0d rk=%0h exp no valid key", rnd, rk);
        end else begin
          e = sq.pop_front();
          chk("rk_rnd_cyc", {rk, rnd, cyc}, {e.rk, e.rnd, e.cyc});
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_spurious got done=1 at cyc %0d exp 0", cyc);
        end else begin
          d = dq.pop_front();
          chk("done_cyc_rk", {cyc, rk, rk_vld, busy}, {d.cyc, d.hold, 2'b00});
        end
      end
`ifdef AES_INV_KS_ZEROIZE_EN
      if (!rk_vld) chk("zeroize_rk", rk, 128'h0);
`endif
    end
  end

  initial begin
    build_sbox();
    rst = 1;
    ld = 0;
    key = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {rk, rnd, rk_vld, busy, done}, '0);
    rst = 0;
    issue_ld(KA);
    base = last_e0;
    repeat (4) @(negedge clk);
    issue_ld(128'hffeeddccbbaa99887766554433221100);
    repeat (5) @(negedge clk);
    chk("vecA_r10", {rk, rnd, rk_vld}, {128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd10, 1'b1});
    repeat (4) @(negedge clk);
    issue_ld(128'h0f0e0d0c0b0a09080706050403020100);
    repeat (6) @(negedge clk);
    chk("vecA_done", {done, rk_vld, busy}, 3'b100);
    issue_ld(KC);
    base = last_e0;
    repeat (10) @(negedge clk);
    chk("vecC_r10", {rk, rnd}, {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10});
    repeat (14) @(negedge clk);
    chk("vecC_hold", {rk, rk_vld, busy, done}, {ZER ? 128'h0 : KC, 3'b000});
    for (int n = 0; n < 2; n++) begin
      issue_ld({$urandom, $urandom, $urandom, $urandom});
      repeat (22) @(negedge clk);
    end
    issue_ld({$urandom, $urandom, $urandom, $urandom});
    repeat (13) @(negedge clk);
    #2 rst = 1;
    #1 chk("rst_async", {rk, rnd, rk_vld, busy, done}, '0);
    active = 0;
    sq.delete();
    dq.delete();
    repeat (3) @(negedge clk);
    rst = 0;
    issue_ld({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 40 && (sq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    chk("drain", sq.size() + dq.size(), 0);
    repeat (3) @(negedge clk);
    chk("final_hold", {rk, rk_vld, busy, done}, {ZER ? 128'h0 : lastk, 3'b000});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
